// File: rtl/lsu_pkg.sv
// lsu_pkg: shared encodings for the load/store unit.
// Operation codes, FSM states, byte-enable patterns.
package lsu_pkg;

  localparam logic [2:0] LD_LB  = 3'd0;
  localparam logic [2:0] LD_LH  = 3'd1;
  localparam logic [2:0] LD_LW  = 3'd2;
  localparam logic [2:0] LD_LBU = 3'd4;
  localparam logic [2:0] LD_LHU = 3'd5;

  localparam logic [1:0] ST_SB = 2'd0;
  localparam logic [1:0] ST_SH = 2'd1;
  localparam logic [1:0] ST_SW = 2'd2;

  localparam logic [3:0] BE_B0  = 4'b0001;
  localparam logic [3:0] BE_LO  = 4'b0011;
  localparam logic [3:0] BE_HI  = 4'b1100;
  localparam logic [3:0] BE_ALL = 4'b1111;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_DONE
  } lsu_state_e;

  typedef enum logic [1:0] {
    SZ_B,
    SZ_H,
    SZ_W
  } lsu_size_e;

  // Unlisted load codes fall back to a full word.
  function automatic lsu_size_e ld_size(
    input logic [2:0] op
  );
    case (op)
      LD_LB, LD_LBU: return SZ_B;
      LD_LH, LD_LHU: return SZ_H;
      LD_LW:         return SZ_W;
      default:       return SZ_W;
    endcase
  endfunction

  // Code 3 stores a full word.
  function automatic lsu_size_e st_size(
    input logic [1:0] op
  );
    case (op)
      ST_SB:   return SZ_B;
      ST_SH:   return SZ_H;
      ST_SW:   return SZ_W;
      default: return SZ_W;
    endcase
  endfunction

endpackage

// File: rtl/lsu_ctrl_if.sv
// lsu_ctrl_if: data-memory bus between LSU and memory.
// Request/grant plus read-response channel.
interface lsu_ctrl_if #(
  parameter int ADDR_W = 32
) ();

  logic              bus_req;
  logic              bus_we;
  logic [ADDR_W-1:0] bus_addr;
  logic [31:0]       bus_wdata;
  logic [3:0]        bus_be;
  logic              bus_gnt;
  logic              bus_rvalid;
  logic [31:0]       bus_rdata;

  modport master (
    output bus_req,
    output bus_we,
    output bus_addr,
    output bus_wdata,
    output bus_be,
    input  bus_gnt,
    input  bus_rvalid,
    input  bus_rdata
  );

  modport slave (
    input  bus_req,
    input  bus_we,
    input  bus_addr,
    input  bus_wdata,
    input  bus_be,
    output bus_gnt,
    output bus_rvalid,
    output bus_rdata
  );

endinterface

// File: rtl/lsu_align.sv
// lsu_align: byte-lane steering, load extension and
// alignment check. Purely combinational.
module lsu_align
  import lsu_pkg::*;
(
  input  logic        mem_rw,
  input  logic [2:0]  load_op,
  input  logic [1:0]  write_op,
  input  logic [1:0]  off,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [3:0]  be,
  output logic [31:0] wrep,
  output logic [31:0] ldata,
  output logic        misalign
);

  lsu_size_e   sz;
  lsu_size_e   ssz;
  logic [31:0] shifted;
  logic [7:0]  lb;
  logic [15:0] lh;

  // Access size and the alignment fault it implies.
  always_comb begin
    ssz = st_size(write_op);
    sz  = mem_rw ? ssz : ld_size(load_op);
    misalign = 1'b0;
    unique case (sz)
      SZ_H:    misalign = off[0];
      SZ_W:    misalign = |off;
      default: misalign = 1'b0;
    endcase
  end

  // Store lanes: enables follow the offset, data is replicated.
  always_comb begin
    be   = BE_ALL;
    wrep = wdata;
    unique case (ssz)
      SZ_B: begin
        be   = BE_B0 << off;
        wrep = {4{wdata[7:0]}};
      end
      SZ_H: begin
        be   = off[1] ? BE_HI : BE_LO;
        wrep = {2{wdata[15:0]}};
      end
      default: begin
        be   = BE_ALL;
        wrep = wdata;
      end
    endcase
  end

  // Load extract then sign or zero extend.
  always_comb begin
    shifted = rword >> {off, 3'b000};
    lb      = shifted[7:0];
    lh      = off[1] ? rword[31:16] : rword[15:0];
    ldata   = rword;
    unique case (load_op)
      LD_LB:   ldata = {{24{lb[7]}}, lb};
      LD_LH:   ldata = {{16{lh[15]}}, lh};
      LD_LBU:  ldata = {24'd0, lb};
      LD_LHU:  ldata = {16'd0, lh};
      default: ldata = rword;
    endcase
  end

endmodule

// File: rtl/lsu_ctrl.sv
// lsu_ctrl: load/store unit FSM driving the data bus.
// Stalls the core until each access completes.
module lsu_ctrl
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              mem_rw,
  input  logic [2:0]        load_op,
  input  logic [1:0]        write_op,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata,
  output logic              done,
  output logic              misalign,
  output logic              stall,
  lsu_ctrl_if.master        bus
);

  lsu_state_e        state_q, state_d;
  logic              mem_rw_q, mem_rw_d;
  logic [2:0]        load_op_q, load_op_d;
  logic [1:0]        write_op_q, write_op_d;
  logic [1:0]        off_q, off_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              done_q, done_d;
  logic              mis_q, mis_d;
  logic              bus_req_q, bus_req_d;
  logic              bus_we_q, bus_we_d;
  logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
  logic [31:0]       bus_wdata_q, bus_wdata_d;
  logic [3:0]        bus_be_q, bus_be_d;

  logic        idle;
  logic        al_rw;
  logic [2:0]  al_lop;
  logic [1:0]  al_wop;
  logic [1:0]  al_off;
  logic [3:0]  al_be;
  logic [31:0] al_wrep;
  logic [31:0] al_ldata;
  logic        al_mis;

  assign idle = (state_q == S_IDLE);

  // Aligner sees live inputs at accept, latched op afterwards.
  always_comb begin
    al_rw  = idle ? mem_rw   : mem_rw_q;
    al_lop = idle ? load_op  : load_op_q;
    al_wop = idle ? write_op : write_op_q;
    al_off = idle ? addr[1:0] : off_q;
  end

  lsu_align u_align (
    .mem_rw   (al_rw),
    .load_op  (al_lop),
    .write_op (al_wop),
    .off      (al_off),
    .wdata    (wdata),
    .rword    (bus.bus_rdata),
    .be       (al_be),
    .wrep     (al_wrep),
    .ldata    (al_ldata),
    .misalign (al_mis)
  );

  // Next-state and next-output decode.
  always_comb begin
    state_d     = state_q;
    mem_rw_d    = mem_rw_q;
    load_op_d   = load_op_q;
    write_op_d  = write_op_q;
    off_d       = off_q;
    rdata_d     = rdata_q;
    done_d      = 1'b0;
    mis_d       = 1'b0;
    bus_req_d   = bus_req_q;
    bus_we_d    = bus_we_q;
    bus_addr_d  = bus_addr_q;
    bus_wdata_d = bus_wdata_q;
    bus_be_d    = bus_be_q;
    unique case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          mem_rw_d   = mem_rw;
          load_op_d  = load_op;
          write_op_d = write_op;
          off_d      = addr[1:0];
          if (al_mis) begin
            state_d = S_DONE;
            done_d  = 1'b1;
            mis_d   = 1'b1;
          end else begin
            state_d     = S_REQ;
            bus_req_d   = 1'b1;
            bus_we_d    = mem_rw;
            bus_addr_d  = {addr[ADDR_W-1:2], 2'b00};
            bus_wdata_d = al_wrep;
            bus_be_d    = mem_rw ? al_be : BE_ALL;
          end
        end
      end
      S_REQ: begin
        if (bus.bus_gnt) begin
          bus_req_d = 1'b0;
          bus_we_d  = 1'b0;
          if (mem_rw_q) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (bus.bus_rvalid) begin
          rdata_d = al_ldata;
          state_d = S_DONE;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and registered outputs; reset drops bus_req at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      mem_rw_q    <= 1'b0;
      load_op_q   <= 3'd0;
      write_op_q  <= 2'd0;
      off_q       <= 2'd0;
      rdata_q     <= 32'd0;
      done_q      <= 1'b0;
      mis_q       <= 1'b0;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= '0;
      bus_wdata_q <= 32'd0;
      bus_be_q    <= 4'd0;
    end else begin
      state_q     <= state_d;
      mem_rw_q    <= mem_rw_d;
      load_op_q   <= load_op_d;
      write_op_q  <= write_op_d;
      off_q       <= off_d;
      rdata_q     <= rdata_d;
      done_q      <= done_d;
      mis_q       <= mis_d;
      bus_req_q   <= bus_req_d;
      bus_we_q    <= bus_we_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
      bus_be_q    <= bus_be_d;
    end
  end

  assign req_ready     = idle;
  assign stall         = (state_q == S_REQ) ||
                         (state_q == S_WAIT) ||
                         (idle && req_valid);
  assign rdata         = rdata_q;
  assign done          = done_q;
  assign misalign      = mis_q;
  assign bus.bus_req   = bus_req_q;
  assign bus.bus_we    = bus_we_q;
  assign bus.bus_addr  = bus_addr_q;
  assign bus.bus_wdata = bus_wdata_q;
  assign bus.bus_be    = bus_be_q;

endmodule

// File: doc/lsu_ctrl.md
# lsu_ctrl

Load/store unit sitting directly downstream of the instruction controller in the single-issue RISC-V core. Consumes the controller's `MemRW`, `load_op` and `write_op` decisions plus the ALU-computed address and rs2 data. Runs a multi-cycle request/grant/response transaction on the data-memory bus, performs byte-lane steering and load sign/zero extension, and stalls the core until the access completes.

## Interface
Parameters:
- `ADDR_W`, 32: byte-address width on the core and bus side.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `req_valid`  in  1  core presents a memory instruction.
- `req_ready`  out  1  LSU can accept a request (IDLE only).
- `mem_rw`  in  1  1 = store, 0 = load.
- `load_op`  in  3  0 LB, 1 LH, 2 LW, 4 LBU, 5 LHU; 3/6/7 treated as LW.
- `write_op`  in  2  0 SB, 1 SH, 2 SW; 3 treated as SW.
- `addr`  in  ADDR_W  byte address (rs1+imm).
- `wdata`  in  32  store data (rs2).
- `rdata`  out  32  formatted load result, valid while `done`.
- `done`  out  1  one-cycle completion pulse.
- `misalign`  out  1  one-cycle pulse with `done` on an alignment fault.
- `stall`  out  1  core must hold its PC and pipeline.
- `bus_req`  out  1  bus request.
- `bus_we`  out  1  bus write enable.
- `bus_addr`  out  ADDR_W  word-aligned address (`addr[1:0]` forced to 0).
- `bus_wdata`  out  32  lane-replicated store data.
- `bus_be`  out  4  byte enables.
- `bus_gnt`  in  1  bus accepted the request this cycle.
- `bus_rvalid`  in  1  read data valid.
- `bus_rdata`  in  32  read data word.

## Operation
- FSM states: IDLE, REQ, WAIT, DONE.
- IDLE: `req_ready`=1. On `req_valid`: latch `mem_rw`, op, `addr`, `wdata`. Misaligned (half at `addr[0]`=1, word at `addr[1:0]`≠0) → DONE with `misalign` set, no bus activity. Otherwise → REQ.
- REQ: `bus_req`=1; `bus_we`, `bus_addr`, `bus_be`, `bus_wdata` held stable until `bus_gnt`. On gnt: store → DONE; load → WAIT.
- WAIT: on `bus_rvalid`, capture formatted data into `rdata` → DONE.
- DONE: `done`=1 for one cycle → IDLE. A new request is not accepted in DONE.
- Store lanes: SB `be`=1<<`addr[1:0]`, data = byte ×4. SH `be`=0011 (`addr[1]`=0) / 1100 (`addr[1]`=1), data = half ×2. SW `be`=1111.
- Load format: select byte `addr[1:0]` or half `addr[1]` from `bus_rdata`. Sign-extend LB/LH, zero-extend LBU/LHU, pass the word for LW.
- `stall` = (state ∈ {REQ, WAIT}) or (IDLE and `req_valid`). It is 0 in DONE.
- `bus_rvalid` outside WAIT is ignored. `bus_gnt` outside REQ is ignored.

## Timing
- Reset: state IDLE. `bus_req`, `bus_we`, `done`, `misalign` = 0. `rdata`, `bus_addr`, `bus_wdata`, `bus_be` = 0. `req_ready` = 1.
- Reset mid-transaction: `bus_req` drops asynchronously. A late `rvalid` after reset is discarded.
- Store, immediate gnt: accept at cycle 0, REQ at cycle 1 (gnt), `done` at cycle 2.
- Load, immediate gnt and next-cycle rvalid: `done` at cycle 3.
- Each gnt-wait or rvalid-wait cycle adds one cycle.
- `bus_rvalid` must arrive no earlier than the cycle after `bus_gnt`.
- Misaligned access: `done`+`misalign` at cycle 1.
- All outputs are registered except `req_ready` and `stall`, which decode from state and `req_valid`.

## Structure
- Package `lsu_pkg`: `load_op` / `write_op` encoding constants, FSM state enum, `BE_*` constants.
- Sub-module `lsu_align`: purely combinational. Handles store byte-enable/replication, load extract/extension, and the misalignment check. Instantiated once in `lsu_ctrl`.

## Test plan
- SB `addr`=0x103, `wdata`=0x000000AB, gnt at cycle 1 → `bus_be`=1000, `bus_wdata`=0xABABABAB, `bus_addr`=0x100, `done` at cycle 2.
- LB `addr`=0x202, `bus_rdata`=0x12F03456 → `rdata`=0xFFFFFFF0. Same access as LBU → 0x000000F0. LH at 0x202 → 0x000012F0.
- LW `addr`=0x300, gnt held off 3 cycles, rvalid 2 cycles later with 0xDEADBEEF → `stall` high throughout, `bus_req` stable, `done` at cycle 7, `rdata`=0xDEADBEEF.
- SH `addr`=0x101 → `misalign`+`done` at cycle 1, `bus_req` never asserted.
- `rst` asserted while in WAIT, then `bus_rvalid` pulses → outputs return to reset values, no `done`, next request proceeds normally.
- `load_op`=6 at 0x40, `bus_rdata`=0x80000001 → treated as LW, `rdata`=0x80000001.
